// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory-access stage (master) and data memory (slave).
// The master raises dmem_req with stable we/addr/wdata and holds them until it samples dmem_ack high.
// dmem_ack completes the access, and dmem_rdata is valid in that same cycle.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: word loads/stores over req/ack with upstream stall,
// registered write-back outputs, misalignment and timeout fault reporting.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  mem_stage_if.master       dmem,
  input  logic              ex_valid_i,
  input  logic [31:0]       alu_result_i,
  input  logic [31:0]       store_data_i,
  input  logic [4:0]        rd_out_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic              wb_sel_i,
  input  logic              wb_fp_en_i,
  input  logic              wb_int_en_i,
  output logic              mem_stall_o,
  output logic              wb_valid_o,
  output logic [31:0]       wb_data_o,
  output logic [4:0]        wb_rd_o,
  output logic              wb_fp_en_q_o,
  output logic              wb_int_en_q_o,
  output logic              mem_fault_o,
  output logic              state_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [4:0]  rd_q, rd_d;
  logic        sel_q, sel_d, fp_q, fp_d, int_q, int_d;
  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_fp_q, wb_fp_d, wb_int_q, wb_int_d;
  logic        fault_q, fault_d;

  logic mem_op, legal, accept, timeout;

  assign mem_op  = ex_valid_i & (mem_read_i | mem_write_i);
  assign legal   = (alu_result_i[1:0] == 2'b00) & ~(mem_read_i & mem_write_i);
  assign accept  = (state_q == S_IDLE) & mem_op & legal;
  // The counter holds the number of WAIT cycles already spent, so the request is held at most TIMEOUT_CYCLES cycles.
  assign timeout = (state_q == S_WAIT) & ~dmem.dmem_ack & (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_WAIT;
      S_WAIT: if (dmem.dmem_ack || timeout) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_stall_o = 1'b0;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    sel_d      = sel_q;
    fp_d       = fp_q;
    int_d      = int_q;
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    wb_fp_d    = wb_fp_q;
    wb_int_d   = wb_int_q;
    fault_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        mem_stall_o = accept;
        if (accept) begin
          req_d   = 1'b1;
          we_d    = mem_write_i;
          addr_d  = {alu_result_i[31:2], 2'b00};
          wdata_d = store_data_i;
          rd_d    = rd_out_i;
          sel_d   = wb_sel_i;
          fp_d    = wb_fp_en_i;
          int_d   = wb_int_en_i;
          cnt_d   = '0;
        end else if (mem_op) begin
          // Misaligned or read+write: retire immediately as a faulting no-op.
          fault_d    = 1'b1;
          wb_valid_d = 1'b1;
          wb_data_d  = alu_result_i;
          wb_rd_d    = rd_out_i;
          wb_fp_d    = 1'b0;
          wb_int_d   = 1'b0;
        end else if (ex_valid_i) begin
          wb_valid_d = 1'b1;
          wb_data_d  = alu_result_i;
          wb_rd_d    = rd_out_i;
          wb_fp_d    = wb_fp_en_i;
          wb_int_d   = wb_int_en_i;
        end
      end
      S_WAIT: begin
        mem_stall_o = ~dmem.dmem_ack;
        if (dmem.dmem_ack) begin
          req_d      = 1'b0;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = sel_q ? dmem.dmem_rdata : addr_q;
          wb_fp_d    = fp_q & ~we_q;
          wb_int_d   = int_q & ~we_q;
        end else if (timeout) begin
          req_d      = 1'b0;
          fault_d    = 1'b1;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = addr_q;
          wb_fp_d    = 1'b0;
          wb_int_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      sel_q      <= 1'b0;
      fp_q       <= 1'b0;
      int_q      <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_fp_q    <= 1'b0;
      wb_int_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      sel_q      <= sel_d;
      fp_q       <= fp_d;
      int_q      <= int_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      wb_fp_q    <= wb_fp_d;
      wb_int_q   <= wb_int_d;
      fault_q    <= fault_d;
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign wb_valid_o      = wb_valid_q;
  assign wb_data_o       = wb_data_q;
  assign wb_rd_o         = wb_rd_q;
  assign wb_fp_en_q_o    = wb_fp_q;
  assign wb_int_en_q_o   = wb_int_q;
  assign mem_fault_o     = fault_q;
  assign state_o         = state_q;

endmodule
